// File: rtl/matrix_accel_pkg.sv
// Shared types for the matrix accelerator: FSM states, post-op mode codes
// and the output saturation helper.
package matrix_accel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MAC  = 2'b01,
    POST = 2'b10,
    OUT  = 2'b11
  } state_e;

  localparam logic [1:0] MODE_SAT   = 2'b00;
  localparam logic [1:0] MODE_RELU  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_ABS   = 2'b11;

  // Clamp a wide signed value into the range of a w-bit signed result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/matrix_accel_postop.sv
// Combinational post-op on a finished dot product: optional bias add
// (MATRIX_ACCEL_BIAS_EN), then mode select and saturation to OUT_WIDTH.
module matrix_accel_postop
  import matrix_accel_pkg::*;
#(
  parameter int ACC_WIDTH = 19,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [1:0]           mode_i,
  input  logic [3:0]           shift_i,
`ifdef MATRIX_ACCEL_BIAS_EN
  input  logic [ACC_WIDTH-1:0] bias_i,
`endif
  output logic [OUT_WIDTH-1:0] res_o
);

  logic signed [63:0]          v;
  logic signed [OUT_WIDTH-1:0] r;

  always_comb begin
    v = 64'($signed(acc_i));
`ifdef MATRIX_ACCEL_BIAS_EN
    v = v + 64'($signed(bias_i));
`endif
    case (mode_i)
      MODE_RELU:  r = (v < 64'sd0) ? '0 : OUT_WIDTH'(saturate(v, OUT_WIDTH));
      MODE_SHIFT: r = OUT_WIDTH'(saturate(v >>> shift_i, OUT_WIDTH));
      MODE_ABS:   r = OUT_WIDTH'(saturate((v < 64'sd0) ? -v : v, OUT_WIDTH));
      default:    r = OUT_WIDTH'(saturate(v, OUT_WIDTH));
    endcase
  end

  assign res_o = r;

endmodule

// File: rtl/matrix_accel_engine.sv
// Runtime-sized signed matrix multiply C = A*B with one sequential MAC and a
// valid/ready result stream. Optional per-column bias: MATRIX_ACCEL_BIAS_EN.
module matrix_accel_engine
  import matrix_accel_pkg::*;
#(
  parameter int MAX_M      = 4,
  parameter int MAX_N      = 4,
  parameter int MAX_P      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_N) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            a_wen,
  input  logic [$clog2(MAX_M*MAX_N)-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0]           a_data,
  input  logic                            b_wen,
  input  logic [$clog2(MAX_N*MAX_P)-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0]           b_data,
`ifdef MATRIX_ACCEL_BIAS_EN
  input  logic                            bias_wen,
  input  logic [$clog2(MAX_P)-1:0]        bias_addr,
  input  logic [DATA_WIDTH-1:0]           bias_data,
`endif
  input  logic [$clog2(MAX_M):0]          cfg_m,
  input  logic [$clog2(MAX_N):0]          cfg_n,
  input  logic [$clog2(MAX_P):0]          cfg_p,
  input  logic [1:0]                      cfg_mode,
  input  logic [3:0]                      cfg_shift,
  input  logic                            start,
  output logic                            busy,
  output logic                            cfg_err,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [$clog2(MAX_M)-1:0]        out_row,
  output logic [$clog2(MAX_P)-1:0]        out_col,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done
);

  localparam int MW  = $clog2(MAX_M) + 1;
  localparam int NW  = $clog2(MAX_N) + 1;
  localparam int PW  = $clog2(MAX_P) + 1;
  localparam int IW  = $clog2(MAX_M);
  localparam int KW  = $clog2(MAX_N);
  localparam int JW  = $clog2(MAX_P);
  localparam int AAW = $clog2(MAX_M*MAX_N);
  localparam int BAW = $clog2(MAX_N*MAX_P);

  logic [DATA_WIDTH-1:0] a_mem [MAX_M*MAX_N];
  logic [DATA_WIDTH-1:0] b_mem [MAX_N*MAX_P];

  state_e                  state_q, state_d;
  logic [MW-1:0]           m_q, m_d;
  logic [NW-1:0]           n_q, n_d;
  logic [PW-1:0]           p_q, p_d;
  logic [1:0]              mode_q, mode_d;
  logic [3:0]              shift_q, shift_d;
  logic [IW-1:0]           i_q, i_d;
  logic [KW-1:0]           k_q, k_d;
  logic [JW-1:0]           j_q, j_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    done_q, done_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]           out_row_q, out_row_d;
  logic [JW-1:0]           out_col_q, out_col_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0] a_el, b_el;
  logic signed [ACC_WIDTH-1:0]  prod;
  logic [OUT_WIDTH-1:0]         post_res;
  logic                         dims_ok, k_last, j_last, elem_last;

  // Operand buffers are deliberately left out of reset; writes are frozen while a job runs.
  always_ff @(posedge clk) begin
    if (a_wen && !busy_q) a_mem[a_addr] <= a_data;
    if (b_wen && !busy_q) b_mem[b_addr] <= b_data;
  end

`ifdef MATRIX_ACCEL_BIAS_EN
  logic [DATA_WIDTH-1:0]       bias_mem [MAX_P];
  logic signed [ACC_WIDTH-1:0] bias_ext;
  always_ff @(posedge clk) begin
    if (bias_wen && !busy_q) bias_mem[bias_addr] <= bias_data;
  end
  assign bias_ext = ACC_WIDTH'($signed(bias_mem[j_q]));
`endif

  assign a_el = $signed(a_mem[AAW'(int'(i_q) * MAX_N + int'(k_q))]);
  assign b_el = $signed(b_mem[BAW'(int'(k_q) * MAX_P + int'(j_q))]);
  assign prod = ACC_WIDTH'(a_el) * ACC_WIDTH'(b_el);

  assign dims_ok   = (cfg_m != '0) && (int'(cfg_m) <= MAX_M) &&
                     (cfg_n != '0) && (int'(cfg_n) <= MAX_N) &&
                     (cfg_p != '0) && (int'(cfg_p) <= MAX_P);
  assign k_last    = ({1'b0, k_q} == n_q - NW'(1));
  assign j_last    = ({1'b0, j_q} == p_q - PW'(1));
  assign elem_last = j_last && ({1'b0, i_q} == m_q - MW'(1));

  matrix_accel_postop #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_postop (
    .acc_i   (acc_q),
    .mode_i  (mode_q),
    .shift_i (shift_q),
`ifdef MATRIX_ACCEL_BIAS_EN
    .bias_i  (bias_ext),
`endif
    .res_o   (post_res)
  );

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    p_d         = p_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    i_d         = i_q;
    k_d         = k_q;
    j_d         = j_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    cfg_err_d   = 1'b0;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            m_d     = cfg_m;
            n_d     = cfg_n;
            p_d     = cfg_p;
            mode_d  = cfg_mode;
            shift_d = cfg_shift;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            busy_d  = 1'b1;
            state_d = MAC;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        k_d   = k_q + KW'(1);
        if (k_last) state_d = POST;
      end
      POST: begin
        out_data_d  = post_res;
        out_row_d   = i_q;
        out_col_d   = j_q;
        out_last_d  = elem_last;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (j_last) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      n_q         <= '0;
      p_q         <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      i_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      p_q         <= p_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      i_q         <= i_d;
      k_q         <= k_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_accel_engine.sv
// Randomized, self-checking bench for matrix_accel_engine against a plain
// arithmetic model of C = A*B with post-op (bias via MATRIX_ACCEL_BIAS_EN).
`timescale 1ns/1ps
module tb_matrix_accel_engine;

  localparam int MX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_wen = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [7:0]  a_data = '0;
  logic        b_wen = 1'b0;
  logic [3:0]  b_addr = '0;
  logic [7:0]  b_data = '0;
  logic [2:0]  cfg_m = '0, cfg_n = '0, cfg_p = '0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_shift = '0;
  logic        start = 1'b0;
  logic        busy, cfg_err, out_last, out_valid, done;
  logic [15:0] out_data;
  logic [1:0]  out_row, out_col;
  logic        out_ready = 1'b1;
`ifdef MATRIX_ACCEL_BIAS_EN
  logic        bias_wen = 1'b0;
  logic [1:0]  bias_addr = '0;
  logic [7:0]  bias_data = '0;
`endif

  always #5 clk = ~clk;

  matrix_accel_engine dut (
    .clk(clk), .rst_n(rst_n),
    .a_wen(a_wen), .a_addr(a_addr), .a_data(a_data),
    .b_wen(b_wen), .b_addr(b_addr), .b_data(b_data),
`ifdef MATRIX_ACCEL_BIAS_EN
    .bias_wen(bias_wen), .bias_addr(bias_addr), .bias_data(bias_data),
`endif
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .start(start),
    .busy(busy), .cfg_err(cfg_err),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: matrices as plain integer arrays, row-major stride 4.
  int am[16];
  int bm[16];
  int biasm[4];

  typedef struct {
    longint data;
    int     row;
    int     col;
    int     last;
  } elem_t;
  elem_t expq[$];

  function automatic longint satv(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint model_elem(input int i, input int j, input int n,
                                        input int mode, input int sh);
    longint acc = 0;
    for (int k = 0; k < n; k++) acc += longint'(am[i*MX+k]) * longint'(bm[k*MX+j]);
    acc += biasm[j];
    case (mode)
      1:       return (acc < 0) ? 0 : satv(acc);
      2:       return satv(acc >>> sh);
      3:       return satv((acc < 0) ? -acc : acc);
      default: return satv(acc);
    endcase
  endfunction

  task automatic build_expected(input int m, input int n, input int p, input int mode, input int sh);
    elem_t e;
    expq.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < p; j++) begin
        e.data = model_elem(i, j, n, mode, sh);
        e.row  = i;
        e.col  = j;
        e.last = (i == m-1 && j == p-1) ? 1 : 0;
        expq.push_back(e);
      end
  endtask

  // Tasks below start and end just after a rising edge.
  task automatic write_a(input int addr, input int val);
    a_wen = 1'b1; a_addr = 4'(addr); a_data = 8'(val); am[addr] = val;
    @(posedge clk); #1;
    a_wen = 1'b0;
  endtask

  task automatic write_b(input int addr, input int val);
    b_wen = 1'b1; b_addr = 4'(addr); b_data = 8'(val); bm[addr] = val;
    @(posedge clk); #1;
    b_wen = 1'b0;
  endtask

  task automatic clear_bias();
`ifdef MATRIX_ACCEL_BIAS_EN
    for (int j = 0; j < MX; j++) begin
      bias_wen = 1'b1; bias_addr = 2'(j); bias_data = 8'd0; biasm[j] = 0;
      @(posedge clk); #1;
    end
    bias_wen = 1'b0;
`endif
  endtask

  task automatic fill_rand();
    for (int x = 0; x < 16; x++) write_a(x, int'($urandom_range(0, 255)) - 128);
    for (int x = 0; x < 16; x++) write_b(x, int'($urandom_range(0, 255)) - 128);
`ifdef MATRIX_ACCEL_BIAS_EN
    for (int j = 0; j < MX; j++) begin
      biasm[j] = int'($urandom_range(0, 255)) - 128;
      bias_wen = 1'b1; bias_addr = 2'(j); bias_data = 8'(biasm[j]);
      @(posedge clk); #1;
    end
    bias_wen = 1'b0;
`endif
  endtask

  // out_ready generator: 0 tied high, 1 random, 2 repeating 1-0-0-1.
  int rdy_mode = 0;
  int pidx = 0;
  initial begin
    int pat[4] = '{1, 0, 0, 1};
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = 1'(pat[pidx]); pidx = (pidx + 1) % 4; end
      endcase
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Output checker: every handshake pops the model queue; stalls must hold.
  initial begin
    elem_t       e;
    bit          held = 1'b0;
    logic [15:0] hd;
    logic [1:0]  hr, hc;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 1'b0;
      else if (out_valid) begin
        if (held) begin
          chk("stall_data", longint'($signed(out_data)), longint'($signed(hd)));
          chk("stall_row", out_row, hr);
          chk("stall_col", out_col, hc);
        end
        if (expq.size() == 0) chk("unexpected_valid", out_valid, 0);
        else begin
          e = expq[0];
          if (out_ready) begin
            chk("out_data", longint'($signed(out_data)), e.data);
            chk("out_row", out_row, e.row);
            chk("out_col", out_col, e.col);
            chk("out_last", out_last, e.last);
            void'(expq.pop_front());
            held = 1'b0;
          end else begin
            held = 1'b1; hd = out_data; hr = out_row; hc = out_col;
          end
        end
      end else held = 1'b0;
    end
  end

  bit sc_en = 1'b0;
  int sc_addr = 0;
  int sc_val = 0;

  task automatic run_job(input int m, input int n, input int p, input int mode,
                         input int sh, input bit chk_lat);
    int cyc;
    int d0;
    @(posedge clk); #1;
    cfg_m = 3'(m); cfg_n = 3'(n); cfg_p = 3'(p);
    cfg_mode = 2'(mode); cfg_shift = 4'(sh); start = 1'b1;
    if (sc_en) begin
      a_wen = 1'b1; a_addr = 4'(sc_addr); a_data = 8'(sc_val); am[sc_addr] = sc_val;
    end
    build_expected(m, n, p, mode, sh);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0; a_wen = 1'b0; sc_en = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    if (chk_lat) chk("latency", cyc, m*p*(n+2));
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_end", busy, 0);
    chk("all_elems_out", expq.size(), 0);
    chk("done_count", done_cnt - d0, 1);
    expq.delete();
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_bias();

    // 2x2x2 reference product.
    write_a(0, 1); write_a(1, 2); write_a(4, 3); write_a(5, 4);
    write_b(0, 5); write_b(1, 6); write_b(4, 7); write_b(5, 8);
    chk("pin_c00", model_elem(0, 0, 2, 0, 0), 19);
    chk("pin_c01", model_elem(0, 1, 2, 0, 0), 22);
    chk("pin_c10", model_elem(1, 0, 2, 0, 0), 43);
    chk("pin_c11", model_elem(1, 1, 2, 0, 0), 50);
    rdy_mode = 0;
    run_job(2, 2, 2, 0, 0, 1'b1);

    // Negative dot product through every mode.
    write_a(0, -100); write_a(1, -100); write_b(0, 100); write_b(4, 100);
    chk("pin_sat", model_elem(0, 0, 2, 0, 0), -20000);
    chk("pin_relu", model_elem(0, 0, 2, 1, 0), 0);
    chk("pin_shift", model_elem(0, 0, 2, 2, 4), -1250);
    chk("pin_abs", model_elem(0, 0, 2, 3, 0), 20000);
    for (int md = 0; md < 4; md++) run_job(1, 2, 1, md, 4, 1'b1);

    // Full-size job that overflows the output range.
    for (int x = 0; x < 16; x++) write_a(x, -128);
    for (int x = 0; x < 16; x++) write_b(x, -128);
    chk("pin_clamp", model_elem(3, 3, 4, 0, 0), 32767);
    run_job(4, 4, 4, 0, 0, 1'b1);

    // Backpressure pattern on a 1x1x3 job.
    fill_rand();
    pidx = 0; rdy_mode = 2;
    run_job(1, 1, 3, 0, 0, 1'b0);
    rdy_mode = 0;

    // Rejected starts.
    cfg_m = 3'd1; cfg_n = 3'd0; cfg_p = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_n0", cfg_err, 1);
    chk("busy_n0", busy, 0);
    @(posedge clk); #1;
    chk("cfg_err_pulse", cfg_err, 0);
    cfg_m = 3'(MX + 1); cfg_n = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_mbig", cfg_err, 1);
    chk("busy_mbig", busy, 0);

    // Writes and start while busy must be ignored.
    clear_bias();
    write_a(0, 5); write_b(0, 3);
    fork
      run_job(2, 2, 2, 0, 0, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        a_wen = 1'b1; a_addr = 4'd0; a_data = 8'd77; start = 1'b1; cfg_n = 3'd0;
        @(posedge clk); #1;
        a_wen = 1'b0; start = 1'b0;
        chk("no_err_while_busy", cfg_err, 0);
        chk("busy_held", busy, 1);
      end
    join
    chk("pin_a_kept", model_elem(0, 0, 1, 0, 0), 15);
    run_job(1, 1, 1, 0, 0, 1'b1);

    // Reset in the middle of MAC aborts the job silently.
    fill_rand();
    cfg_m = 3'd4; cfg_n = 3'd4; cfg_p = 3'd4; cfg_mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    run_job(3, 2, 4, 1, 0, 1'b1);

    // Randomized jobs.
    for (int t = 0; t < 10; t++) begin
      int m, n, p, md, sh;
      fill_rand();
      m = int'($urandom_range(1, 4)); n = int'($urandom_range(1, 4));
      p = int'($urandom_range(1, 4)); md = int'($urandom_range(0, 3));
      sh = int'($urandom_range(0, 15));
      rdy_mode = t % 2;
      if (t == 2 || t == 6) begin
        sc_en = 1'b1; sc_addr = 0; sc_val = int'($urandom_range(0, 255)) - 128;
      end
      run_job(m, n, p, md, sh, rdy_mode == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=<2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
